shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencing controller for the serial shift-register datapath. Accepts a parallel word over a valid/ready handshake, drives it bit-serially (LSB first) into the shift register's serial input, and captures the bits returning on its serial output after the register's fixed latency. It then presents the recovered word with a match flag and keeps a saturating count of mismatches. It sits between a parallel producer/consumer and the shift register, and doubles as a built-in self-check for that datapath.

## Interface
Parameters:
- LENGTH, 8, word width in bits and number of serial bits per transfer
- SR_LATENCY, 8, cycles from a bit driven on o_sr_din to the same bit on i_sr_dout (equals the shift register LENGTH)
- ERR_W, 16, width of the mismatch counter

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_in_word  in  LENGTH  parallel word to send
- i_in_valid  in  1  i_in_word is valid
- o_in_ready  out  1  controller can accept a word
- o_sr_din  out  1  serial bit to the shift register input
- i_sr_dout  in  1  serial bit from the shift register output
- o_out_word  out  LENGTH  recovered word
- o_out_valid  out  1  o_out_word and o_match are valid
- i_out_ready  in  1  consumer accepts the recovered word
- o_match  out  1  recovered word equals the sent word
- o_busy  out  1  transfer in progress (state is not IDLE)
- o_err_cnt  out  ERR_W  saturating count of accepted mismatched words

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - o_in_ready=1.
  - When i_in_valid=1, latch i_in_word into tx_word, clear cnt to 0, clear cap_word, and go to RUN.
- RUN:
  - cnt counts 0 .. LENGTH+SR_LATENCY-1.
  - o_sr_din = tx_word[cnt] while cnt<LENGTH, else 0 (zero fill).
  - When cnt>=SR_LATENCY, cap_word[cnt-SR_LATENCY] <= i_sr_dout.
  - At cnt=LENGTH+SR_LATENCY-1, go to DONE.
- DONE:
  - o_out_valid=1, o_out_word=cap_word, o_match=(cap_word==tx_word).
  - All three are held stable until i_out_ready=1.
  - On the handshake: if o_match=0, o_err_cnt increments, saturating at 2^ERR_W-1. Then go to IDLE.
- o_in_ready is 1 only in IDLE. A word offered in RUN or DONE is not accepted and must be held by the producer.
- i_in_word is sampled only on the accept cycle. Later changes do not affect the transfer in flight.
- o_sr_din = 0 in IDLE and DONE.
- Counter width: $clog2(LENGTH+SR_LATENCY). Comparisons use unsigned arithmetic.

## Timing
- Reset (i_rst_n=0 at a rising edge) values:
  - state=IDLE, o_in_ready=1, o_sr_din=0, o_out_valid=0, o_out_word=0, o_match=0, o_busy=0, o_err_cnt=0, cnt=0, tx_word=0, cap_word=0.
- Reset mid-RUN or mid-DONE aborts the transfer: no output handshake, no counter update.
- Cycle timing for a word accepted at edge E0:
  - RUN begins the cycle after E0.
  - Bit k is driven during RUN cycle k.
  - Bit k is captured at the edge that ends RUN cycle k+SR_LATENCY.
- o_out_valid rises LENGTH+SR_LATENCY cycles after E0.
- A handshake in the same cycle o_out_valid first rises is legal. The controller returns to IDLE on the next cycle.
- Minimum spacing between accepts: LENGTH+SR_LATENCY+2 cycles (RUN, one DONE cycle, one IDLE cycle).
- The error counter updates on the edge that completes the DONE handshake. It is visible on the following cycle.

## Structure
- Package shift_seq_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE, 2-bit);
  - the default LENGTH and SR_LATENCY constants;
  - a function giving the counter width.
- Sub-module: sat_counter (parameter W; inputs inc and clear; output value, saturating). It implements o_err_cnt.
- Everything else is a single always_ff plus combinational output decode.
- The shift register itself is not instantiated inside. It connects externally through o_sr_din and i_sr_dout.

## Test plan
All scenarios use LENGTH=8, SR_LATENCY=8, with the shift register connected.
- Reset then idle: hold i_rst_n=0 for 2 cycles, then release -> o_in_ready=1, o_out_valid=0, o_err_cnt=0, o_sr_din=0.
- Send 8'hA5 with i_out_ready=1 -> o_sr_din shows 1,0,1,0,0,1,0,1 on RUN cycles 0-7; o_out_valid rises 16 cycles after accept; o_out_word=8'hA5, o_match=1, o_err_cnt stays 0.
- Back-pressure: send 8'h3C with i_out_ready=0 for 5 cycles -> o_out_valid and o_out_word=8'h3C hold stable; a new i_in_valid is refused (o_in_ready=0); the handshake completes on the first cycle i_out_ready=1.
- Fault injection: force i_sr_dout=0 while sending 8'hFF -> o_out_word=8'h00, o_match=0; o_err_cnt=1 after the handshake.
- Reset mid-RUN: assert i_rst_n=0 at RUN cycle 5 of 8'h81 -> next cycle state=IDLE, o_busy=0, no o_out_valid; the next word 8'h81 round-trips with o_match=1.
- Saturation: with ERR_W=2, cause 5 mismatches -> o_err_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the shift-register sequencing controller.
// No logic; latency and backpressure are defined by the modules that import it.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_LENGTH     = 8;
    localparam int DEF_SR_LATENCY = 8;

    function automatic int cnt_width(input int length, input int latency);
        return ((length + latency) > 1) ? $clog2(length + latency) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; value updates one cycle after inc.
// No backpressure: increments past all-ones are dropped.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_value
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            o_value <= '0;
        end else if (i_inc && (o_value != '1)) begin
            o_value <= o_value + W'(1);
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Serialises a word LSB-first into an external shift register and recovers it; result after LENGTH+SR_LATENCY cycles.
// Accepts only in IDLE; the recovered word is held in DONE until the consumer takes it.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int LENGTH     = DEF_LENGTH,
    parameter int SR_LATENCY = DEF_SR_LATENCY,
    parameter int ERR_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [LENGTH-1:0] i_in_word,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_sr_din,
    input  logic              i_sr_dout,
    output logic [LENGTH-1:0] o_out_word,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_match,
    output logic              o_busy,
    output logic [ERR_W-1:0]  o_err_cnt
);

    localparam int            CW     = cnt_width(LENGTH, SR_LATENCY);
    localparam logic [CW-1:0] LEN_C  = CW'(LENGTH);
    localparam logic [CW-1:0] LAT_C  = CW'(SR_LATENCY);
    localparam logic [CW-1:0] LAST_C = CW'(LENGTH + SR_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [LENGTH-1:0] r_tx_word;
    logic [LENGTH-1:0] r_cap_word;
    logic              w_match;
    logic              w_err_inc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tx_word  <= '0;
            r_cap_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_tx_word  <= i_in_word;
                        r_cnt      <= '0;
                        r_cap_word <= '0;
                    end
                end
                RUN: begin
                    // Shifting in from the MSB leaves the first returned bit at bit 0.
                    if (r_cnt >= LAT_C) begin
                        r_cap_word <= (r_cap_word >> 1) | (LENGTH'(i_sr_dout) << (LENGTH - 1));
                    end
                    if (r_cnt != LAST_C) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_match = (r_cap_word == r_tx_word);

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_sr_din    = 1'b0;
        o_out_valid = 1'b0;
        o_out_word  = '0;
        o_match     = 1'b0;
        o_busy      = 1'b1;
        w_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                o_busy     = 1'b0;
                if (i_in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                // Selected bit is zero once cnt passes the word, giving the zero fill.
                o_sr_din = (r_cnt < LEN_C) && |(r_tx_word & (LENGTH'(1) << r_cnt));
                if (r_cnt == LAST_C) w_state_nxt = DONE;
            end
            DONE: begin
                o_out_valid = 1'b1;
                o_out_word  = r_cap_word;
                o_match     = w_match;
                if (i_out_ready) begin
                    w_err_inc   = !w_match;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_inc  (w_err_inc),
        .i_clear(1'b0),
        .o_value(o_err_cnt)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: vector table, hand sequences and random transfers through a modelled shift register.
// Channel corruption is a per-transfer XOR mask, so the reference result is simply word ^ mask.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_word = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flip = 1'b0;
    logic [7:0] sr = 8'h00;
    logic       sr_dout;

    logic        o_in_ready, o_sr_din, o_out_valid, o_match, o_busy;
    logic [7:0]  o_out_word;
    logic [15:0] o_err_cnt;
    logic        o_in_ready2, o_sr_din2, o_out_valid2, o_match2, o_busy2;
    logic [7:0]  o_out_word2;
    logic [1:0]  o_err_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    int exp_err2 = 0;

    always #5 clk = ~clk;

    // External 8-stage shift register; flip corrupts bits on their way in.
    always @(posedge clk) sr <= {sr[6:0], o_sr_din ^ flip};
    assign sr_dout = sr[7];

    shift_seq_ctrl #(.LENGTH(8), .SR_LATENCY(8), .ERR_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_word(in_word), .i_in_valid(in_valid),
        .o_in_ready(o_in_ready), .o_sr_din(o_sr_din), .i_sr_dout(sr_dout),
        .o_out_word(o_out_word), .o_out_valid(o_out_valid), .i_out_ready(out_ready),
        .o_match(o_match), .o_busy(o_busy), .o_err_cnt(o_err_cnt)
    );

    shift_seq_ctrl #(.LENGTH(8), .SR_LATENCY(8), .ERR_W(2)) u_dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_word(in_word), .i_in_valid(in_valid),
        .o_in_ready(o_in_ready2), .o_sr_din(o_sr_din2), .i_sr_dout(sr_dout),
        .o_out_word(o_out_word2), .o_out_valid(o_out_valid2), .i_out_ready(out_ready),
        .o_match(o_match2), .o_busy(o_busy2), .o_err_cnt(o_err_cnt2)
    );

    typedef struct {
        logic [7:0] word;
        logic [7:0] mask;
        int         hold;
        logic [7:0] exp_word;
        logic       exp_match;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic xfer(input logic [7:0] w, input logic [7:0] m, input int hold,
                        input logic [7:0] ew, input logic em);
        @(negedge clk);
        chk("in_ready_idle", o_in_ready, 1);
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = 8'($urandom);
        for (int k = 0; k < 16; k++) begin
            flip = (k < 8) ? m[k] : 1'b0;
            chk("sr_din", o_sr_din, (k < 8) ? w[k] : 1'b0);
            if (k == 0) chk("busy_run", o_busy, 1);
            if (k == 15) chk("valid_low_run", o_out_valid, 0);
            if (k == 15 && hold == 0) out_ready = 1'b1;
            @(negedge clk);
        end
        flip = 1'b0;
        chk("out_valid", o_out_valid, 1);
        chk("out_word", o_out_word, ew);
        chk("match", o_match, em);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_word  = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", o_out_valid, 1);
            chk("hold_word", o_out_word, ew);
            chk("hold_match", o_match, em);
            chk("hold_in_ready", o_in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (m != 8'h00) begin
            if (exp_err < 65535) exp_err++;
            if (exp_err2 < 3) exp_err2++;
        end
        chk("busy_after", o_busy, 0);
        chk("valid_after", o_out_valid, 0);
        chk("err_cnt", o_err_cnt, exp_err);
        chk("err_cnt_sat", o_err_cnt2, exp_err2);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h00, 0, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 8'h00, 5, 8'h3C, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 0, 8'h00, 1'b0};
        vecs[3] = '{8'h81, 8'h00, 1, 8'h81, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 2, 8'h01, 1'b0};
        vecs[5] = '{8'hF0, 8'h80, 0, 8'h70, 1'b0};
        vecs[6] = '{8'h5A, 8'h5A, 3, 8'h00, 1'b0};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_err", o_err_cnt, 0);
        chk("rst_sr_din", o_sr_din, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_out_word", o_out_word, 0);
        chk("rst_match", o_match, 0);

        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].word, vecs[i].mask, vecs[i].hold, vecs[i].exp_word, vecs[i].exp_match);
        end

        // Abort 8'h81 at RUN cycle 5.
        @(negedge clk);
        in_word  = 8'h81;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_abort_busy", o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err  = 0;
        exp_err2 = 0;
        chk("abort_busy", o_busy, 0);
        chk("abort_in_ready", o_in_ready, 1);
        chk("abort_valid", o_out_valid, 0);
        chk("abort_err", o_err_cnt, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_valid", o_out_valid, 0);
        xfer(8'h81, 8'h00, 0, 8'h81, 1'b1);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] w, m;
            w = 8'($urandom);
            m = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            xfer(w, m, $urandom_range(0, 3), w ^ m, (w ^ m) == w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
